// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface program_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] insn_addr;
  logic [31:0] insn_din;
  logic        insn_we;

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, insn_addr, insn_din, insn_we
  );

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, insn_addr, insn_din, insn_we
  );
endinterface

// File: rtl/program_loader.sv
// Assembles a framed little-endian byte stream into instruction words, writes
// them from START_ADDR upward and releases the core once the checksum matches.
module program_loader #(
  parameter logic [31:0] START_ADDR = 32'h8000_0000,
  parameter int          MAX_WORDS  = 4096
) (
  input  logic              clk,
  input  logic              reset_n,
  program_loader_if.slave   bus,
  input  logic              reload,
  output logic              run,
  output logic              error,
  output logic              busy
);
  localparam int CNT_W = $clog2(MAX_WORDS + 1);

  localparam logic [2:0] S_HDR  = 3'd0;
  localparam logic [2:0] S_DATA = 3'd1;
  localparam logic [2:0] S_CSUM = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0] nwords_q, nwords_d;
  logic [23:0]      shift_q, shift_d;
  logic [7:0]       csum_q, csum_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      din_q, din_d;
  logic             we_q, we_d;
  logic             rdy_q, rdy_d;

  logic             accept;
  logic [31:0]      word_full;

  assign accept    = bus.rx_valid && rdy_q;
  // Incoming byte lands on top, so after four bytes byte 0 sits in bits 7:0.
  assign word_full = {bus.rx_data, shift_q};

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    nwords_d   = nwords_q;
    shift_d    = shift_q;
    csum_d     = csum_q;
    addr_d     = addr_q;
    din_d      = din_q;
    we_d       = 1'b0;

    if (reload) begin
      state_d    = S_HDR;
      byte_cnt_d = '0;
      word_cnt_d = '0;
      nwords_d   = '0;
      shift_d    = '0;
      csum_d     = '0;
    end else if (accept) begin
      case (state_q)
        S_HDR: begin
          shift_d    = word_full[31:8];
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            nwords_d = word_full[CNT_W-1:0];
            if (word_full > 32'(MAX_WORDS))
              state_d = S_ERR;
            else if (word_full == 32'd0)
              state_d = S_CSUM;
            else
              state_d = S_DATA;
          end
        end
        S_DATA: begin
          shift_d    = word_full[31:8];
          byte_cnt_d = byte_cnt_q + 2'd1;
          csum_d     = csum_q + bus.rx_data;
          if (byte_cnt_q == 2'd3) begin
            we_d       = 1'b1;
            din_d      = word_full;
            addr_d     = START_ADDR + 32'({word_cnt_q, 2'b00});
            word_cnt_d = word_cnt_q + 1'b1;
            if (word_cnt_d == nwords_q)
              state_d = S_CSUM;
          end
        end
        S_CSUM: state_d = (bus.rx_data == csum_q) ? S_RUN : S_ERR;
        default: ;
      endcase
    end

    // Ready is registered from the next state so it never follows rx_valid.
    rdy_d = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_CSUM);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_HDR;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      nwords_q   <= '0;
      shift_q    <= '0;
      csum_q     <= '0;
      addr_q     <= START_ADDR;
      din_q      <= '0;
      we_q       <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      nwords_q   <= nwords_d;
      shift_q    <= shift_d;
      csum_q     <= csum_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      we_q       <= we_d;
      rdy_q      <= rdy_d;
    end
  end

  assign bus.rx_ready  = rdy_q;
  assign bus.insn_addr = addr_q;
  assign bus.insn_din  = din_q;
  assign bus.insn_we   = we_q;
  assign run           = (state_q == S_RUN);
  assign error         = (state_q == S_ERR);
  assign busy          = (state_q == S_DATA) || (state_q == S_CSUM);
endmodule

// File: tb/tb_program_loader.sv
// Directed scenarios for the program loader with a negedge write monitor.
module tb_program_loader;
  localparam logic [31:0] START = 32'h8000_0000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic reload = 1'b0;
  logic run, error, busy;

  program_loader_if bus();

  program_loader dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave),
    .reload (reload),
    .run    (run),
    .error  (error),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  int          wc[$];
  logic [7:0]  tx[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.insn_we === 1'b1) begin
      wa.push_back(bus.insn_addr);
      wd.push_back(bus.insn_din);
      wc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic clear_mon();
    wa.delete(); wd.delete(); wc.delete();
  endtask

  task automatic idle();
    bus.rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    if (gap > 0) begin
      bus.rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    t = 0;
    while (bus.rx_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      checks++; errors++;
      $display("FAIL send_byte_timeout rx_ready=%b expected 1", bus.rx_ready);
    end
    @(negedge clk);
  endtask

  task automatic send_q(input int maxgap);
    for (int i = 0; i < tx.size(); i++)
      send_byte(tx[i], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
    tx.delete();
  endtask

  task automatic do_reload();
    bus.rx_valid = 1'b0;
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic load_n2_body();
    tx = {8'h02, 8'h00, 8'h00, 8'h00,
          8'h13, 8'h00, 8'h00, 8'h00,
          8'h93, 8'h00, 8'h10, 8'h00};
  endtask

  task automatic check_n2_writes(input string tag);
    checks++;
    if (wa.size() != 2) begin
      errors++; $display("FAIL %s_count got %0d exp 2", tag, wa.size());
    end else begin
      checks++;
      if (wa[0] !== START) begin errors++; $display("FAIL %s_addr0 got %h exp %h", tag, wa[0], START); end
      checks++;
      if (wd[0] !== 32'h0000_0013) begin errors++; $display("FAIL %s_data0 got %h exp 00000013", tag, wd[0]); end
      checks++;
      if (wa[1] !== START + 32'd4) begin errors++; $display("FAIL %s_addr1 got %h exp 80000004", tag, wa[1]); end
      checks++;
      if (wd[1] !== 32'h0010_0093) begin errors++; $display("FAIL %s_data1 got %h exp 00100093", tag, wd[1]); end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", bus.rx_ready); end
    checks++; if (bus.insn_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b exp 0", bus.insn_we); end
    checks++; if (bus.insn_addr !== START) begin errors++; $display("FAIL rst_addr got %h exp %h", bus.insn_addr, START); end
    checks++; if (bus.insn_din !== 32'd0) begin errors++; $display("FAIL rst_din got %h exp 0", bus.insn_din); end
    checks++; if ({run, error, busy} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", {run, error, busy}); end
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.rx_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", bus.rx_ready); end
  endtask

  task automatic test_full_rate();
    clear_mon();
    load_n2_body();
    send_q(0);
    checks++; if (run !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL full_pre_csum run=%b busy=%b exp 0 1", run, busy); end
    send_byte(8'hB6, 0);
    checks++; if (run !== 1'b1) begin errors++; $display("FAIL full_run got %b exp 1", run); end
    checks++; if (bus.rx_ready !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL full_ready_err ready=%b err=%b exp 0 0", bus.rx_ready, error); end
    idle(); idle();
    check_n2_writes("full");
    if (wc.size() == 2) begin
      checks++;
      if (wc[1] - wc[0] != 4) begin errors++; $display("FAIL full_spacing got %0d exp 4", wc[1] - wc[0]); end
    end
  endtask

  task automatic test_bad_csum();
    do_reload();
    checks++; if (run !== 1'b0) begin errors++; $display("FAIL bad_reload_run got %b exp 0", run); end
    clear_mon();
    load_n2_body();
    send_q(0);
    send_byte(8'hB7, 0);
    checks++; if (error !== 1'b1 || run !== 1'b0) begin errors++; $display("FAIL bad_flags err=%b run=%b exp 1 0", error, run); end
    idle(); idle();
    check_n2_writes("bad");
    do_reload();
    checks++; if (error !== 1'b0 || busy !== 1'b0 || bus.rx_ready !== 1'b1) begin
      errors++; $display("FAIL bad_after_reload err=%b busy=%b ready=%b exp 0 0 1", error, busy, bus.rx_ready);
    end
    clear_mon();
    load_n2_body();
    send_q(0);
    send_byte(8'hB6, 0);
    checks++; if (run !== 1'b1) begin errors++; $display("FAIL bad_reload_run got %b exp 1", run); end
    idle(); idle();
    check_n2_writes("bad_retry");
  endtask

  task automatic test_overflow_zero();
    do_reload();
    clear_mon();
    tx = {8'h01, 8'h10, 8'h00, 8'h00};
    send_q(0);
    checks++; if (error !== 1'b1 || bus.rx_ready !== 1'b0) begin errors++; $display("FAIL ovf_flags err=%b ready=%b exp 1 0", error, bus.rx_ready); end
    idle(); idle();
    checks++; if (wa.size() != 0) begin errors++; $display("FAIL ovf_writes got %0d exp 0", wa.size()); end
    do_reload();
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL ovf_reload_err got %b exp 0", error); end
    tx = {8'h00, 8'h00, 8'h00, 8'h00};
    send_q(0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy got %b exp 1", busy); end
    send_byte(8'h00, 0);
    checks++; if (run !== 1'b1) begin errors++; $display("FAIL zero_run got %b exp 1", run); end
    idle(); idle();
    checks++; if (wa.size() != 0) begin errors++; $display("FAIL zero_writes got %0d exp 0", wa.size()); end
  endtask

  task automatic test_gaps();
    do_reload();
    clear_mon();
    load_n2_body();
    tx.push_back(8'hB6);
    send_q(5);
    checks++; if (run !== 1'b1) begin errors++; $display("FAIL gaps_run got %b exp 1", run); end
    idle(); idle();
    check_n2_writes("gaps");
  endtask

  task automatic test_reset_midload();
    do_reload();
    clear_mon();
    tx = {8'h04, 8'h00, 8'h00, 8'h00,
          8'h44, 8'h33, 8'h22, 8'h11, 8'h55};
    send_q(0);
    checks++; if (bus.insn_din !== 32'h1122_3344) begin errors++; $display("FAIL mid_word0 got %h exp 11223344", bus.insn_din); end
    bus.rx_data  = 8'h66;
    bus.rx_valid = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus.rx_ready !== 1'b0 || bus.insn_we !== 1'b0) begin errors++; $display("FAIL mid_ready_we ready=%b we=%b exp 0 0", bus.rx_ready, bus.insn_we); end
    checks++; if (bus.insn_addr !== START || bus.insn_din !== 32'd0) begin errors++; $display("FAIL mid_addr_din addr=%h din=%h exp %h 0", bus.insn_addr, bus.insn_din, START); end
    checks++; if ({run, error, busy} !== 3'b000) begin errors++; $display("FAIL mid_flags got %b exp 000", {run, error, busy}); end
    bus.rx_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.rx_ready !== 1'b1) begin errors++; $display("FAIL mid_release_ready got %b exp 1", bus.rx_ready); end
    clear_mon();
    load_n2_body();
    tx.push_back(8'hB6);
    send_q(0);
    checks++; if (run !== 1'b1) begin errors++; $display("FAIL mid_run got %b exp 1", run); end
    idle(); idle();
    check_n2_writes("mid");
  endtask

  task automatic test_reload_coincident();
    do_reload();
    clear_mon();
    tx = {8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00};
    send_q(0);
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b1;
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    bus.rx_valid = 1'b0;
    checks++; if (busy !== 1'b0 || bus.rx_ready !== 1'b1 || run !== 1'b0) begin
      errors++; $display("FAIL coin_state busy=%b ready=%b run=%b exp 0 1 0", busy, bus.rx_ready, run);
    end
    tx = {8'h01, 8'h00, 8'h00, 8'h00, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h0E};
    send_q(0);
    checks++; if (run !== 1'b1) begin errors++; $display("FAIL coin_run got %b exp 1", run); end
    idle(); idle();
    checks++;
    if (wa.size() != 1) begin
      errors++; $display("FAIL coin_count got %0d exp 1", wa.size());
    end else begin
      checks++;
      if (wa[0] !== START || wd[0] !== 32'hAABB_CCDD) begin
        errors++; $display("FAIL coin_write got %h/%h exp %h/aabbccdd", wa[0], wd[0], START);
      end
    end
  endtask

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    test_reset();
    test_full_rate();
    test_bad_csum();
    test_overflow_zero();
    test_gaps();
    test_reset_midload();
    test_reload_coincident();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
